// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, special bytes, parser states and
// the per-status data-length / entry-state helpers.
package midi_pkg;

   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] POLY_AT  = 4'hA;
   localparam logic [3:0] CTRL     = 4'hB;
   localparam logic [3:0] PROG     = 4'hC;
   localparam logic [3:0] CH_AT    = 4'hD;
   localparam logic [3:0] PITCH    = 4'hE;

   localparam logic [7:0] SYSEX_START = 8'hF0;
   localparam logic [7:0] SYSEX_END   = 8'hF7;
   localparam logic [7:0] RT_MIN      = 8'hF8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      NOTE1 = 3'd1,
      NOTE2 = 3'd2,
      SKIP1 = 3'd3,
      SKIP2 = 3'd4,
      SYSEX = 3'd5
   } midi_state_e;

   function automatic logic [1:0] chan_msg_len(input logic [3:0] hi);
      logic [1:0] len;
      case (hi)
         PROG, CH_AT:                             len = 2'd1;
         NOTE_OFF, NOTE_ON, POLY_AT, CTRL, PITCH: len = 2'd2;
         default:                                 len = 2'd0;
      endcase
      return len;
   endfunction

   // First state after a channel status byte (also where running status resumes).
   function automatic midi_state_e entry_state(input logic [3:0] hi, input logic [1:0] len);
      midi_state_e st;
      if ((hi == NOTE_OFF) || (hi == NOTE_ON)) begin
         st = NOTE1;
      end else if (len == 2'd1) begin
         st = SKIP1;
      end else if (len == 2'd2) begin
         st = SKIP2;
      end else begin
         st = IDLE;
      end
      return st;
   endfunction

endpackage

// File: rtl/midi_byte_class.sv
// Combinational MIDI byte classifier, reusable by any MIDI byte consumer.
module midi_byte_class
   import midi_pkg::*;
(
   input  logic [7:0] byte_in,
   output logic       is_data,
   output logic       is_chan_status,
   output logic       is_sys_common,
   output logic       is_realtime,
   output logic [1:0] msg_len
);

   // Range decode of the byte; msg_len is only meaningful for channel status.
   always_comb begin
      is_data        = 1'b0;
      is_chan_status = 1'b0;
      is_sys_common  = 1'b0;
      is_realtime    = 1'b0;
      msg_len        = 2'd0;
      if (byte_in[7] == 1'b0) begin
         is_data = 1'b1;
      end else if (byte_in >= RT_MIN) begin
         is_realtime = 1'b1;
      end else if (byte_in >= SYSEX_START) begin
         is_sys_common = 1'b1;
      end else begin
         is_chan_status = 1'b1;
         msg_len        = chan_msg_len(byte_in[7:4]);
      end
   end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI channel-voice parser with running status: emits one-cycle note-on/off
// events and silently skips every other message type.
module midi_msg_parser
   import midi_pkg::*;
#(
   parameter bit         FILTER_EN = 1'b0,
   parameter logic [3:0] CHANNEL   = 4'h0,
   parameter bit         VEL0_OFF  = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   input  logic       frame_err,
   output logic       ev_valid,
   output logic       ev_on,
   output logic [3:0] ev_chan,
   output logic [6:0] ev_note,
   output logic [6:0] ev_vel,
   output logic [7:0] run_status
);

   midi_state_e state_r, next_state_s;
   logic [7:0]  status_r, status_nx_s;
   logic [6:0]  note_r, note_nx_s;
   logic        emit_s, chan_ok_s, on_s;
   logic        ev_valid_r, ev_on_r;
   logic [3:0]  ev_chan_r;
   logic [6:0]  ev_note_r, ev_vel_r;

   logic        is_data_s, is_chan_status_s, is_sys_common_s, is_realtime_s;
   logic [1:0]  msg_len_s;

   midi_byte_class u_class (
      .byte_in        (byte_in),
      .is_data        (is_data_s),
      .is_chan_status (is_chan_status_s),
      .is_sys_common  (is_sys_common_s),
      .is_realtime    (is_realtime_s),
      .msg_len        (msg_len_s)
   );

   // Parser state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next state, running status and note latch; frame errors win over bytes.
   always_comb begin
      next_state_s = state_r;
      status_nx_s  = status_r;
      note_nx_s    = note_r;
      emit_s       = 1'b0;
      if (frame_err) begin
         next_state_s = IDLE;
         status_nx_s  = 8'h00;
      end else if (byte_valid) begin
         if (is_realtime_s) begin
            next_state_s = state_r;
         end else if (is_sys_common_s) begin
            status_nx_s = 8'h00;
            if (byte_in == SYSEX_START) begin
               next_state_s = SYSEX;
            end else begin
               next_state_s = IDLE;
            end
         end else if (is_chan_status_s) begin
            status_nx_s  = byte_in;
            next_state_s = entry_state(byte_in[7:4], msg_len_s);
         end else if (is_data_s) begin
            case (state_r)
               IDLE:  next_state_s = IDLE;
               NOTE1: begin
                  note_nx_s    = byte_in[6:0];
                  next_state_s = NOTE2;
               end
               NOTE2: begin
                  emit_s       = 1'b1;
                  next_state_s = NOTE1;
               end
               SKIP2: next_state_s = SKIP1;
               SKIP1: next_state_s = entry_state(status_r[7:4], chan_msg_len(status_r[7:4]));
               SYSEX: next_state_s = SYSEX;
               default: begin
                  next_state_s = IDLE;
                  status_nx_s  = 8'h00;
               end
            endcase
         end else begin
            next_state_s = state_r;
         end
      end else begin
         next_state_s = state_r;
      end
   end

   // Event attributes for a note message completing on this byte.
   always_comb begin
      if (FILTER_EN && (status_r[3:0] != CHANNEL)) begin
         chan_ok_s = 1'b0;
      end else begin
         chan_ok_s = 1'b1;
      end
      if (status_r[7:4] == NOTE_ON) begin
         if (byte_in[6:0] != 7'd0) begin
            on_s = 1'b1;
         end else if (VEL0_OFF) begin
            on_s = 1'b0;
         end else begin
            on_s = 1'b1;
         end
      end else begin
         on_s = 1'b0;
      end
   end

   // Running status, note latch and registered event outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         status_r   <= 8'h00;
         note_r     <= 7'd0;
         ev_valid_r <= 1'b0;
         ev_on_r    <= 1'b0;
         ev_chan_r  <= 4'd0;
         ev_note_r  <= 7'd0;
         ev_vel_r   <= 7'd0;
      end else begin
         status_r   <= status_nx_s;
         note_r     <= note_nx_s;
         ev_valid_r <= emit_s & chan_ok_s;
         if (emit_s && chan_ok_s) begin
            ev_on_r   <= on_s;
            ev_chan_r <= status_r[3:0];
            ev_note_r <= note_r;
            ev_vel_r  <= byte_in[6:0];
         end
      end
   end

   assign ev_valid   = ev_valid_r;
   assign ev_on      = ev_on_r;
   assign ev_chan    = ev_chan_r;
   assign ev_note    = ev_note_r;
   assign ev_vel     = ev_vel_r;
   assign run_status = status_r;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Randomized + directed bench for midi_msg_parser; three parameter variants
// share one byte stream and are compared against a message-level model.
module tb_midi_msg_parser;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic       frame_err;

   logic       ev_valid_w [3];
   logic       ev_on_w    [3];
   logic [3:0] ev_chan_w  [3];
   logic [6:0] ev_note_w  [3];
   logic [6:0] ev_vel_w   [3];
   logic [7:0] run_status_w [3];

   always #5 clk = ~clk;

   // Variant 0: defaults; 1: VEL0_OFF=0; 2: FILTER_EN=1, CHANNEL=3.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      midi_msg_parser #(
         .FILTER_EN (g == 2),
         .CHANNEL   (4'h3),
         .VEL0_OFF  (g != 1)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .byte_in    (byte_in),
         .byte_valid (byte_valid),
         .frame_err  (frame_err),
         .ev_valid   (ev_valid_w[g]),
         .ev_on      (ev_on_w[g]),
         .ev_chan    (ev_chan_w[g]),
         .ev_note    (ev_note_w[g]),
         .ev_vel     (ev_vel_w[g]),
         .run_status (run_status_w[g])
      );
   end

   int pass_cnt = 0;
   int chk_cnt  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: running status plus a list of pending data bytes.
   bit         cfg_vel0off [3] = '{1'b1, 1'b0, 1'b1};
   bit         cfg_filter  [3] = '{1'b0, 1'b0, 1'b1};
   int         rs;
   int         dq[$];
   bit         exp_valid [3];
   bit         exp_on    [3];
   int         exp_chan  [3];
   int         exp_note  [3];
   int         exp_vel   [3];

   function automatic int data_len(input int s);
      int hi = s / 16;
      return ((hi == 12) || (hi == 13)) ? 1 : 2;
   endfunction

   task automatic model_step(input bit bv, input int b, input bit fe, input bit r);
      for (int k = 0; k < 3; k++) exp_valid[k] = 1'b0;
      if (r) begin
         rs = 0;
         dq.delete();
         for (int k = 0; k < 3; k++) begin
            exp_on[k] = 1'b0; exp_chan[k] = 0; exp_note[k] = 0; exp_vel[k] = 0;
         end
      end else if (fe) begin
         rs = 0;
         dq.delete();
      end else if (bv) begin
         if (b >= 248) begin
            rs = rs;
         end else if (b >= 240) begin
            rs = 0;
            dq.delete();
         end else if (b >= 128) begin
            rs = b;
            dq.delete();
         end else if (rs != 0) begin
            dq.push_back(b);
            if (dq.size() == data_len(rs)) begin
               if ((rs / 16 == 8) || (rs / 16 == 9)) begin
                  for (int k = 0; k < 3; k++) begin
                     if (!cfg_filter[k] || (rs % 16 == 3)) begin
                        exp_valid[k] = 1'b1;
                        exp_chan[k]  = rs % 16;
                        exp_note[k]  = dq[0];
                        exp_vel[k]   = dq[1];
                        exp_on[k]    = (rs / 16 == 9) && ((dq[1] != 0) || !cfg_vel0off[k]);
                     end
                  end
               end
               dq.delete();
            end
         end
      end
   endtask

   // Check current outputs, then drive one cycle of inputs and advance the model.
   task automatic cycle(input bit bv, input logic [7:0] b, input bit fe, input bit r);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("ev_valid[%0d]", k), ev_valid_w[k], exp_valid[k]);
         chk($sformatf("ev_on[%0d]", k), ev_on_w[k], exp_on[k]);
         chk($sformatf("ev_chan[%0d]", k), ev_chan_w[k], exp_chan[k]);
         chk($sformatf("ev_note[%0d]", k), ev_note_w[k], exp_note[k]);
         chk($sformatf("ev_vel[%0d]", k), ev_vel_w[k], exp_vel[k]);
         chk($sformatf("run_status[%0d]", k), run_status_w[k], rs);
      end
      byte_valid = bv;
      byte_in    = b;
      frame_err  = fe;
      rst        = r;
      model_step(bv, int'(b), fe, r);
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1'b1, b, 1'b0, 1'b0);
   endtask

   task automatic idle();
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   int         r_sel;
   bit         r_bv, r_fe, r_rst;
   logic [7:0] r_b;

   initial begin
      rst = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; frame_err = 1'b0;
      model_step(1'b0, 0, 1'b0, 1'b1);
      @(posedge clk);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      idle();

      send(8'h92); send(8'h3C); send(8'h64); idle();
      chk("tp1_valid", ev_valid_w[0], 32'd1);
      chk("tp1_on", ev_on_w[0], 32'd1);
      chk("tp1_chan", ev_chan_w[0], 32'd2);
      chk("tp1_note", ev_note_w[0], 32'h3C);
      chk("tp1_vel", ev_vel_w[0], 32'h64);
      chk("tp1_rs", run_status_w[0], 32'h92);

      send(8'h90); send(8'h40); send(8'h50); send(8'h40); send(8'h00); idle();
      chk("tp2_off", ev_on_w[0], 32'd0);
      chk("tp2_v0on", ev_on_w[1], 32'd1);

      send(8'h90); send(8'h3C); send(8'hF8); send(8'h7F); idle();
      send(8'hC1); send(8'h05); send(8'hB0); send(8'h07); send(8'h64);
      send(8'h81); send(8'h30); send(8'h00); idle();
      chk("tp4_chan", ev_chan_w[0], 32'd1);
      send(8'h90); send(8'h3C); cycle(1'b0, 8'h00, 1'b1, 1'b0); send(8'h64); idle();
      chk("tp5_rs", run_status_w[0], 32'h00);
      send(8'hF0); send(8'h3C); send(8'h40); send(8'hF7); send(8'h3C); send(8'h40); idle();
      send(8'h93); send(8'h3C); send(8'h40); idle();
      chk("tp6_flt_hit", ev_valid_w[2], 32'd1);
      send(8'h94); send(8'h3C); send(8'h40); idle();
      chk("tp6_flt_miss", ev_valid_w[2], 32'd0);
      send(8'h90); send(8'h3C); cycle(1'b0, 8'h00, 1'b0, 1'b1); send(8'h40); idle();

      for (int i = 0; i < 3000; i++) begin
         r_sel = $urandom_range(0, 99);
         r_fe  = ($urandom_range(0, 49) == 0);
         r_rst = ($urandom_range(0, 299) == 0);
         r_bv  = 1'b1;
         if (r_sel < 55) begin
            r_b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 127));
         end else if (r_sel < 70) begin
            r_b = {4'h8 | 4'($urandom_range(0, 1)), 4'($urandom_range(0, 4))};
         end else if (r_sel < 80) begin
            r_b = {4'($urandom_range(10, 14)), 4'($urandom_range(0, 15))};
         end else if (r_sel < 85) begin
            r_b = 8'($urandom_range(248, 255));
         end else if (r_sel < 90) begin
            r_b = 8'($urandom_range(240, 247));
         end else begin
            r_bv = 1'b0;
            r_b  = 8'($urandom_range(0, 255));
         end
         cycle(r_bv, r_b, r_fe, r_rst);
      end
      idle();
      idle();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
